// File: rtl/dcnn_arb_pkg.sv
// Shared arbitration types and constants for the dcnn register-bank arbiters.
package dcnn_arb_pkg;
   localparam int STATE_W        = 1;
   localparam int IDLE_CNT_WIDTH = 8;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping.
module rr_pick #(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  win,
   output logic          vld
);
   always_comb begin
      int idx;
      idx = 0;
      win = '0;
      vld = |req;
      // Walk downward so the nearest requester to ptr overwrites farther ones.
      for (int i = N - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % N;
         if (req[idx]) begin
            win      = '0;
            win[idx] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/edge_reg_write_arbiter.sv
// Round-robin burst arbiter driving one registered data bus and one-hot enables
// into a bank of enable-gated edge registers.
module edge_reg_write_arbiter
   import dcnn_arb_pkg::*;
#(
   parameter int NUM_REQ      = 3,
   parameter int NUM_REGS     = 8,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 3,
   parameter int IDLE_TIMEOUT = 15
) (
   input  logic                                 CLK,
   input  logic                                 RST,
   input  logic [NUM_REQ-1:0]                   req,
   input  logic [NUM_REQ-1:0]                   req_last,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]                   gnt,
   output logic [NUM_REQ-1:0]                   owner,
   output logic [NUM_REGS-1:0]                  reg_en,
   output logic [DATA_WIDTH-1:0]                reg_din,
   output logic                                 addr_err,
   output logic                                 busy
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDLE_CNT_WIDTH-1:0] TO_LIM = IDLE_CNT_WIDTH'(IDLE_TIMEOUT);

   arb_state_t                state;
   logic [PTR_W-1:0]          rr_ptr;
   logic [IDLE_CNT_WIDTH-1:0] idle_cnt;

   logic [NUM_REQ-1:0]        win;
   logic                      win_vld;
   logic [ADDR_WIDTH-1:0]     sel_addr;
   logic [DATA_WIDTH-1:0]     sel_data;
   logic                      sel_last;
   logic [PTR_W-1:0]          nxt_ptr;
   logic [NUM_REGS-1:0]       en_nxt;
   logic                      accept;
   logic                      addr_ok;
   logic                      timeout_hit;

   rr_pick #(.N(NUM_REQ), .PW(PTR_W)) u_pick (
      .req (req),
      .ptr (rr_ptr),
      .win (win),
      .vld (win_vld)
   );

   assign busy   = (state == BURST);
   assign gnt    = busy ? (req & owner) : '0;
   assign accept = |gnt;

   // Mux the owner's beat; owner is one-hot so at most one slice is picked.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      sel_last = 1'b0;
      nxt_ptr  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (owner[k]) begin
            sel_addr = req_addr[k];
            sel_data = req_data[k];
            sel_last = req_last[k];
            nxt_ptr  = PTR_W'((k + 1) % NUM_REQ);
         end
      end
   end

   always_comb begin
      addr_ok = int'(sel_addr) < NUM_REGS;
      en_nxt  = '0;
      for (int r = 0; r < NUM_REGS; r++)
         en_nxt[r] = (int'(sel_addr) == r);
      timeout_hit = (idle_cnt + 1'b1) == TO_LIM;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         idle_cnt <= '0;
         owner    <= '0;
         reg_en   <= '0;
         reg_din  <= '0;
         addr_err <= 1'b0;
      end else begin
         reg_en   <= '0;
         addr_err <= 1'b0;
         case (state)
            IDLE: begin
               idle_cnt <= '0;
               if (win_vld) begin
                  owner <= win;
                  state <= BURST;
               end
            end
            BURST: begin
               if (accept) begin
                  reg_din  <= sel_data;
                  reg_en   <= en_nxt;
                  addr_err <= !addr_ok;
                  idle_cnt <= '0;
                  if (sel_last) begin
                     state  <= IDLE;
                     owner  <= '0;
                     rr_ptr <= nxt_ptr;
                  end
               end else if (timeout_hit) begin
                  // Silent owner: give up the bank as if the burst had ended.
                  state    <= IDLE;
                  owner    <= '0;
                  rr_ptr   <= nxt_ptr;
                  idle_cnt <= '0;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_edge_reg_write_arbiter.sv
// Directed bench: two instances (8 and 6 registers) share one stimulus set.
module tb_edge_reg_write_arbiter;
   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic [2:0]        req = '0;
   logic [2:0]        req_last = '0;
   logic [2:0][2:0]   req_addr = '0;
   logic [2:0][31:0]  req_data = '0;

   logic [2:0]  gnt, owner, gnt6, owner6;
   logic [7:0]  reg_en;
   logic [5:0]  reg_en6;
   logic [31:0] reg_din, reg_din6;
   logic        addr_err, busy, addr_err6, busy6;

   logic [31:0] bank [8];
   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   edge_reg_write_arbiter u8 (
      .CLK(CLK), .RST(RST), .req(req), .req_last(req_last), .req_addr(req_addr),
      .req_data(req_data), .gnt(gnt), .owner(owner), .reg_en(reg_en),
      .reg_din(reg_din), .addr_err(addr_err), .busy(busy)
   );

   edge_reg_write_arbiter #(.NUM_REGS(6)) u6 (
      .CLK(CLK), .RST(RST), .req(req), .req_last(req_last), .req_addr(req_addr),
      .req_data(req_data), .gnt(gnt6), .owner(owner6), .reg_en(reg_en6),
      .reg_din(reg_din6), .addr_err(addr_err6), .busy(busy6)
   );

   // Bank of enable-gated registers fed by the 8-register instance.
   initial for (int i = 0; i < 8; i++) bank[i] = '0;
   always @(posedge CLK)
      for (int i = 0; i < 8; i++)
         if (reg_en[i]) bank[i] <= reg_din;

   task automatic do_reset();
      RST = 1'b0; req = '0; req_last = '0; req_addr = '0; req_data = '0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
   endtask

   task automatic test_reset();
      RST = 1'b0;
      #3;
      checks++;
      if ({gnt, owner, reg_en, reg_din, addr_err, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: gnt=%b owner=%b reg_en=%h reg_din=%h addr_err=%b busy=%b, want all 0",
                  gnt, owner, reg_en, reg_din, addr_err, busy);
      end
      do_reset();
   endtask

   task automatic test_single_burst();
      do_reset();
      @(negedge CLK);                            // cycle 0
      req = 3'b010; req_addr[1] = 3'd2; req_data[1] = 32'hA; req_last = '0;
      #1 checks++;
      if (gnt !== 3'b000) begin errors++; $display("FAIL sb_gnt_c0: got %b want 000", gnt); end
      @(negedge CLK);                            // cycle 1
      #1 checks++;
      if ({gnt, owner, busy} !== {3'b010, 3'b010, 1'b1}) begin
         errors++; $display("FAIL sb_c1: gnt=%b owner=%b busy=%b want 010 010 1", gnt, owner, busy);
      end
      @(negedge CLK);                            // cycle 2
      checks++;
      if ({reg_en, reg_din} !== {8'h04, 32'hA}) begin
         errors++; $display("FAIL sb_beat0: reg_en=%h reg_din=%h want 04 A", reg_en, reg_din);
      end
      req_addr[1] = 3'd5; req_data[1] = 32'hB;
      #1 checks++;
      if (gnt !== 3'b010) begin errors++; $display("FAIL sb_gnt_c2: got %b want 010", gnt); end
      @(negedge CLK);                            // cycle 3
      checks++;
      if ({reg_en, reg_din} !== {8'h20, 32'hB}) begin
         errors++; $display("FAIL sb_beat1: reg_en=%h reg_din=%h want 20 B", reg_en, reg_din);
      end
      req_addr[1] = 3'd7; req_data[1] = 32'hC; req_last = 3'b010;
      #1 checks++;
      if (gnt !== 3'b010) begin errors++; $display("FAIL sb_gnt_c3: got %b want 010", gnt); end
      @(negedge CLK);                            // cycle 4
      checks++;
      if ({reg_en, reg_din, busy, owner} !== {8'h80, 32'hC, 1'b0, 3'b000}) begin
         errors++; $display("FAIL sb_end: reg_en=%h reg_din=%h busy=%b owner=%b want 80 C 0 000",
                            reg_en, reg_din, busy, owner);
      end
      req = '0; req_last = '0;
      @(negedge CLK);                            // cycle 5
      checks++;
      if ({reg_en, bank[2], bank[5], bank[7]} !== {8'h00, 32'hA, 32'hB, 32'hC}) begin
         errors++; $display("FAIL sb_bank: reg_en=%h bank2=%h bank5=%h bank7=%h want 00 A B C",
                            reg_en, bank[2], bank[5], bank[7]);
      end
   endtask

   task automatic test_round_robin();
      logic [2:0] exp [8];
      exp = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         if (i == 0) begin
            req = 3'b111; req_last = 3'b111;
            req_addr = '0; req_data = {32'h22, 32'h11, 32'h00};
         end
         #1 checks++;
         if (gnt !== exp[i]) begin
            errors++; $display("FAIL rr_gnt_c%0d: got %b want %b", i, gnt, exp[i]);
         end
      end
      req = '0; req_last = '0;
   endtask

   task automatic test_addr_range();
      do_reset();
      @(negedge CLK);                            // cycle 0
      req = 3'b001; req_addr[0] = 3'd7; req_data[0] = 32'h77; req_last = 3'b001;
      @(negedge CLK);                            // cycle 1
      #1 checks++;
      if (gnt6 !== 3'b001) begin errors++; $display("FAIL ar_gnt: got %b want 001", gnt6); end
      @(negedge CLK);                            // cycle 2
      req = '0; req_last = '0;
      checks++;
      if ({reg_en6, addr_err6} !== {6'h00, 1'b1}) begin
         errors++; $display("FAIL ar_oob6: reg_en=%h addr_err=%b want 00 1", reg_en6, addr_err6);
      end
      checks++;
      if ({reg_en, addr_err} !== {8'h80, 1'b0}) begin
         errors++; $display("FAIL ar_inrange8: reg_en=%h addr_err=%b want 80 0", reg_en, addr_err);
      end
      @(negedge CLK);                            // cycle 3
      checks++;
      if ({addr_err6, busy6} !== 2'b00) begin
         errors++; $display("FAIL ar_pulse_end: addr_err=%b busy=%b want 0 0", addr_err6, busy6);
      end
   endtask

   task automatic test_timeout();
      logic saw_en;
      saw_en = 1'b0;
      do_reset();
      @(negedge CLK);                            // cycle 0
      req = 3'b001; req_addr[0] = 3'd1; req_data[0] = 32'h55; req_last = '0;
      @(negedge CLK);                            // cycle 1: one beat accepted
      @(negedge CLK);                            // cycle 2: owner silent, non-owner asks
      req = 3'b010; req_addr[1] = 3'd4; req_last = 3'b010;
      checks++;
      if (reg_en !== 8'h02) begin errors++; $display("FAIL to_beat: reg_en=%h want 02", reg_en); end
      for (int c = 3; c <= 16; c++) begin
         @(negedge CLK);
         if (reg_en !== 8'h00 || gnt !== 3'b000) saw_en = 1'b1;
      end
      checks++;
      if (busy !== 1'b1 || saw_en) begin
         errors++; $display("FAIL to_hold: busy=%b stray_write_or_gnt=%b want 1 0", busy, saw_en);
      end
      @(negedge CLK);                            // cycle 17: 15 silent cycles elapsed
      checks++;
      if ({busy, owner, reg_en} !== {1'b0, 3'b000, 8'h00}) begin
         errors++; $display("FAIL to_release: busy=%b owner=%b reg_en=%h want 0 000 00", busy, owner, reg_en);
      end
      req = 3'b111; req_last = 3'b111;
      @(negedge CLK);                            // cycle 18: pointer moved past 0
      #1 checks++;
      if (gnt !== 3'b010) begin errors++; $display("FAIL to_rr_adv: gnt=%b want 010", gnt); end
      req = '0; req_last = '0;
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      @(negedge CLK);                            // cycle 0
      req = 3'b100; req_addr[2] = 3'd3; req_data[2] = 32'hDEAD; req_last = '0;
      @(negedge CLK);                            // cycle 1: beat accepted
      @(posedge CLK);
      #1 checks++;
      if (reg_en !== 8'h08) begin errors++; $display("FAIL rm_beat: reg_en=%h want 08", reg_en); end
      RST = 1'b0;
      #1 checks++;
      if ({reg_en, owner, busy, gnt} !== {8'h00, 3'b000, 1'b0, 3'b000}) begin
         errors++; $display("FAIL rm_async: reg_en=%h owner=%b busy=%b gnt=%b want 00 000 0 000",
                            reg_en, owner, busy, gnt);
      end
      @(posedge CLK);
      #1 checks++;
      if (bank[3] !== 32'h0) begin errors++; $display("FAIL rm_bank: bank3=%h want 0", bank[3]); end
      req = '0;
      @(negedge CLK);
      RST = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_round_robin();
      test_addr_range();
      test_timeout();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: bench did not finish, want finish before 50000");
      $fatal(1);
   end
endmodule
